bcd_to_binary: RTL and testbench

Sequential packed-BCD to binary converter: accepts a DIGITS-digit packed BCD word over a valid/ready handshake and returns its unsigned binary value after one cycle per digit, using the multiply-by-10-and-add method. It is the inverse path of the display-side binary-to-BCD conversion. It sits between BCD sources (keypad/entry logic, BCD registers) and binary datapath consumers. Invalid digits (>9) are flagged instead of silently converted.

---
 rtl/bcd_to_binary_if.sv | 27 ++
 rtl/bcd_to_binary.sv | 106 ++++++++++
 tb/tb_bcd_to_binary.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/bcd_to_binary_if.sv
// bcd_to_binary_if: handshake bundle for the packed-BCD to binary converter.
//   in_valid/in_ready/in_bcd     : BCD word input channel (source -> converter)
//   out_valid/out_ready/out_bin/out_err : binary result channel (converter -> consumer)
// Modports: master = the environment driving words and taking results,
//           slave  = the converter itself.
interface bcd_to_binary_if #(
    parameter int unsigned DIGITS = 3,
    parameter int unsigned OUT_W  = 10
);
    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   in_bcd;
    logic                  out_valid;
    logic                  out_ready;
    logic [OUT_W-1:0]      out_bin;
    logic                  out_err;

    modport master (
        output in_valid, in_bcd, out_ready,
        input  in_ready, out_valid, out_bin, out_err
    );

    modport slave (
        input  in_valid, in_bcd, out_ready,
        output in_ready, out_valid, out_bin, out_err
    );
endinterface

// File: rtl/bcd_to_binary.sv
// bcd_to_binary: sequential packed-BCD to unsigned binary converter.
// Consumes one digit per cycle, most significant first, with acc = acc*10 + d.
// Any digit above 9 sets the error flag; the reported binary value is then 0.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-high reset, returns to IDLE with outputs cleared
//   bus   : bcd_to_binary_if.slave (input word handshake + result handshake)
module bcd_to_binary #(
    parameter int unsigned DIGITS = 3,
    parameter int unsigned OUT_W  = 10
) (
    input  logic            clock,
    input  logic            reset,
    bcd_to_binary_if.slave  bus
);
    localparam int unsigned CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

    state_t              state_q, state_d;
    logic [4*DIGITS-1:0] shift_q;
    logic [OUT_W-1:0]    acc_q;
    logic                err_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [OUT_W-1:0]    bin_q;
    logic                oerr_q;

    logic [3:0]          digit;
    logic [OUT_W-1:0]    acc_step;
    logic                err_step;

    // acc*10 + d kept at OUT_W bits: the upper four bits of the wider
    // intermediate are discarded by truncation anyway, and modular
    // arithmetic gives the same low OUT_W bits.
    always_comb begin
        digit    = shift_q[4*DIGITS-1 -: 4];
        acc_step = (acc_q << 3) + (acc_q << 1) + OUT_W'(digit);
        err_step = err_q | (digit > 4'd9);
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.in_valid)   state_d = CONVERT;
            CONVERT: if (cnt_q == LAST)  state_d = DONE;
            DONE:    if (bus.out_ready)  state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
    end

    // Outputs: handshake flags decoded from state, result from registers
    always_comb begin
        bus.in_ready  = (state_q == IDLE) && !reset;
        bus.out_valid = (state_q == DONE);
        bus.out_bin   = bin_q;
        bus.out_err   = oerr_q;
    end

    // Datapath
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_q <= '0;
            acc_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            bin_q   <= '0;
            oerr_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        shift_q <= bus.in_bcd;
                        acc_q   <= '0;
                        err_q   <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                CONVERT: begin
                    acc_q   <= acc_step;
                    err_q   <= err_step;
                    shift_q <= shift_q << 4;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        bin_q  <= err_step ? '0 : acc_step;
                        oerr_q <= err_step;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bin_q  <= '0;
                        oerr_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_to_binary.sv
module tb_bcd_to_binary;
    localparam int unsigned DIGITS = 3;
    localparam int unsigned OUT_W  = 10;

    logic clock = 1'b0;
    logic reset = 1'b1;

    bcd_to_binary_if #(.DIGITS(DIGITS), .OUT_W(OUT_W)) bus ();

    bcd_to_binary #(.DIGITS(DIGITS), .OUT_W(OUT_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present a word in IDLE and return 1ns after the accept edge.
    task automatic send(input logic [11:0] w);
        int n;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check("ready_timeout", 0, 1);
        bus.in_valid = 1'b1;
        bus.in_bcd   = w;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        if (lat >= 20) check("result_timeout", 0, 1);
    endtask

    // Full transaction with out_ready held high.
    task automatic xact(input string tag, input logic [11:0] w,
                        input int exp_bin, input logic exp_err);
        int lat;
        send(w);
        wait_result(lat);
        check({tag, "_lat"}, lat, 3);
        check({tag, "_bin"}, bus.out_bin, exp_bin);
        check({tag, "_err"}, bus.out_err, exp_err);
        tick();
        check({tag, "_vdrop"}, bus.out_valid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] words [3];
        int          exp_v [3];
        int          idx, res, cyc, last_t, lat;
        logic        acc;
        logic [11:0] w;
        int unsigned pos;

        bus.in_valid  = 1'b0;
        bus.in_bcd    = '0;
        bus.out_ready = 1'b1;
        reset         = 1'b1;

        // Reset state
        #12;
        check("rst_in_ready",  bus.in_ready,  0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_bin",   bus.out_bin,   0);
        check("rst_out_err",   bus.out_err,   0);
        @(negedge clock);
        reset = 1'b0;
        tick();
        check("idle_ready", bus.in_ready, 1);

        // Basic conversion and latency
        xact("t1", 12'h039, 39, 1'b0);

        // Back-to-back words with in_valid held high
        words[0] = 12'h999; exp_v[0] = 999;
        words[1] = 12'h000; exp_v[1] = 0;
        words[2] = 12'h100; exp_v[2] = 100;
        idx = 0; res = 0; cyc = 0; last_t = 0;
        bus.in_valid = 1'b1;
        bus.in_bcd   = words[0];
        while (res < 3 && cyc < 60) begin
            acc = bus.in_ready && bus.in_valid;
            tick();
            cyc++;
            if (acc) begin
                check("t2_busy", bus.in_ready, 0);
                idx++;
                if (idx < 3) bus.in_bcd = words[idx];
                else         bus.in_valid = 1'b0;
            end
            if (bus.out_valid) begin
                check("t2_bin", bus.out_bin, exp_v[res]);
                check("t2_err", bus.out_err, 0);
                check("t2_done_ready", bus.in_ready, 0);
                if (res > 0) check("t2_gap", cyc - last_t, 5);
                last_t = cyc;
                res++;
            end
        end
        if (res < 3) check("t2_timeout", res, 3);
        bus.in_valid = 1'b0;
        tick();

        // Error flag and no carry-over
        xact("t3_bad",  12'h1A5, 0,   1'b1);
        xact("t3_good", 12'h105, 105, 1'b0);

        // Backpressure: result holds while out_ready is low
        bus.out_ready = 1'b0;
        send(12'h472);
        wait_result(lat);
        check("t4_lat", lat, 3);
        for (int i = 0; i < 6; i++) begin
            check("t4_hold_valid", bus.out_valid, 1);
            check("t4_hold_bin",   bus.out_bin,   472);
            check("t4_hold_err",   bus.out_err,   0);
            check("t4_hold_ready", bus.in_ready,  0);
            bus.in_valid = 1'b1;
            bus.in_bcd   = 12'($urandom);
            tick();
        end
        check("t4_final_bin", bus.out_bin, 472);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("t4_release_valid", bus.out_valid, 0);
        check("t4_release_ready", bus.in_ready,  1);

        // Async reset while the result is held in DONE
        bus.out_ready = 1'b0;
        send(12'h555);
        wait_result(lat);
        check("t5_done_bin", bus.out_bin, 555);
        #3 reset = 1'b1;
        #1;
        check("t5_rd_valid", bus.out_valid, 0);
        check("t5_rd_bin",   bus.out_bin,   0);
        check("t5_rd_ready", bus.in_ready,  0);
        @(negedge clock);
        reset = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("t5_rd_idle", bus.in_ready, 1);

        // Async reset in the second CONVERT cycle
        send(12'h888);
        tick();
        #3 reset = 1'b1;
        #1;
        check("t5_rc_valid", bus.out_valid, 0);
        check("t5_rc_bin",   bus.out_bin,   0);
        check("t5_rc_ready", bus.in_ready,  0);
        @(negedge clock);
        reset = 1'b0;
        tick();
        check("t5_rc_idle", bus.in_ready, 1);
        for (int i = 0; i < 5; i++) begin
            check("t5_no_stale", bus.out_valid, 0);
            tick();
        end
        xact("t5_new", 12'h021, 21, 1'b0);

        // All valid 3-digit words
        for (int unsigned h = 0; h < 10; h++)
            for (int unsigned t = 0; t < 10; t++)
                for (int unsigned o = 0; o < 10; o++)
                    xact("t6_valid", 12'(h*256 + t*16 + o), int'(h*100 + t*10 + o), 1'b0);

        // Random words with at least one digit A-F
        for (int i = 0; i < 60; i++) begin
            w   = 12'($urandom_range(0, 4095));
            pos = $urandom_range(0, 2);
            w[4*pos +: 4] = 4'($urandom_range(10, 15));
            xact("t6_invalid", w, 0, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
